pos_sweep_engine: RTL and testbench
===================================

// Module: pos_sweep_engine
// PURPOSE
//  Parametrised product-of-sums (OR-AND) evaluator with a built-in exhaustive sweeper.
//  On start, steps every N_IN-bit input vector, waits SETTLE cycles per vector, then captures f(vec) into a truth table.
//  f(vec) = AND over clauses k of (|(vec & cfg_mask[k])).
//  Used as the on-chip, cycle-driven replacement for hand-written truth-table benches of OR-AND logic.
// PARAMETERS
//  N_IN     3  input vector width; truth table holds 2**N_IN entries (1..8)
//  NCLAUSE  2  number of OR clauses ANDed together (1..8)
//  SETTLE   1  idle cycles per vector before capture (0..15); 0 = capture on the next cycle
// PORTS
//  clk       in   1               rising-edge clock
//  rst_n     in   1               asynchronous, active-low reset
//  start     in   1               1-cycle request to begin a sweep; honoured only in IDLE
//  abort     in   1               terminate the sweep in progress
//  cfg_mask  in   NCLAUSE*N_IN    clause k = cfg_mask[k*N_IN +: N_IN]; sampled on the accepted start edge
//  busy      out  1               sweep in progress
//  done      out  1               1-cycle pulse when the sweep completes
//  vec_out   out  N_IN            vector currently applied; vec bit N_IN-1 is MSB
//  tt_out    out  2**N_IN         tt_out[v] = f(v)
//  tt_valid  out  1               tt_out holds a complete sweep result
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy, done, tt_valid = 0; vec_out = 0; tt_out = 0; cfg latch = 0.
//  Clause rule: a clause with an all-zero mask is ignored (treated as 1). All clauses zero gives f = 1.
//  FSM states: IDLE, SETTLE, CAPTURE, DONE.
//   IDLE:    start & !abort -> SETTLE. Latch cfg_mask, vec_out=0, settle cnt=0, tt_out=0, tt_valid=0, busy=1.
//   SETTLE:  cnt counts 0..SETTLE-1, then -> CAPTURE. With SETTLE=0 this state is skipped (IDLE/CAPTURE go straight to CAPTURE).
//   CAPTURE: tt_out[vec_out] <= f(vec_out).
//            If vec_out == 2**N_IN-1 -> DONE.
//            Else vec_out++, cnt=0, -> SETTLE (or stay in CAPTURE if SETTLE=0).
//   DONE:    busy=0, done=1 for exactly 1 cycle, tt_valid=1, -> IDLE.
//  Latency: start accepted at edge t0 -> busy=1 from t0+1; done=1 in cycle t0 + 2**N_IN*(SETTLE+1) + 1.
//  tt_valid stays 1 and tt_out stays stable until the next accepted start.
//  Boundaries:
//   - start while busy or in DONE: ignored; the sweep is unaffected.
//   - abort while busy: -> IDLE next cycle; busy=0, no done pulse, tt_valid=0, tt_out keeps partial contents.
//   - start & abort together in IDLE: abort wins; nothing starts.
//   - abort in IDLE or DONE: no effect (done and tt_valid still assert from DONE).
//   - vec_out never wraps: terminal compare on all-ones; vec_out holds 2**N_IN-1 through DONE; it returns to 0 only on the next start.
//   - cfg_mask changes mid-sweep: ignored (latched copy is used).
//   - rst_n low mid-sweep: all outputs reset immediately, without waiting for a clock edge.
//  All outputs are registered; f is combinational from the latched mask and vec_out.
// STRUCTURE
//  Package pos_sweep_pkg:
//   - typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} sweep_state_t
//   - localparam SETTLE_W = 4
//  Sub-module pos_eval: purely combinational f(vec, mask), parametrised by N_IN and NCLAUSE; unit-testable alone.
//  Top level: FSM, settle counter, vector counter, cfg latch, truth-table register.
// TESTING  (N_IN=3, NCLAUSE=2, SETTLE=1; clause0 = cfg_mask[2:0])
//  1. mask0=3'b110, mask1=3'b001 [(A|B)&C], start at t0
//     -> tt_out=8'hA8, tt_valid=1; done pulse at t0+17; busy high t0+1..t0+16.
//  2. Both masks 3'b000 -> tt_out=8'hFF (all clauses ignored).
//  3. mask0=3'b111, mask1=3'b000 -> tt_out=8'hFE.
//  4. Sweep from test 1; assert abort at t0+5
//     -> busy=0 at t0+6; no done; tt_valid=0. Restart gives 8'hA8.
//  5. rst_n=0 at t0+9 (between clock edges) -> busy, tt_out, vec_out = 0 immediately.
//     After release, test 1 passes again.
//  6. start pulses at t0+3 and t0+10 during a sweep -> ignored; a single done at t0+17.
//     SETTLE=0 rerun -> done at t0+9.

Source files
------------

// File: rtl/pos_sweep_pkg.sv
// Shared types and constants for the product-of-sums sweep engine.
package pos_sweep_pkg;

  localparam int unsigned SETTLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    DONE
  } sweep_state_t;

endpackage

// File: rtl/pos_eval.sv
// Combinational OR-AND evaluator: f = AND over clauses of |(vec & mask_k).
// A clause whose mask is all zero does not constrain the result.
module pos_eval #(
  parameter int unsigned N_IN    = 3,
  parameter int unsigned NCLAUSE = 2
) (
  input  logic [N_IN-1:0]         vec,
  input  logic [NCLAUSE*N_IN-1:0] mask,
  output logic                    f_c
);

  logic [N_IN-1:0] clause;

  always_comb begin
    f_c    = 1'b1;
    clause = '0;
    for (int k = 0; k < int'(NCLAUSE); k++) begin
      clause = mask[k*N_IN +: N_IN];
      if ((clause != '0) && ((vec & clause) == '0)) begin
        f_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pos_sweep_engine.sv
// Exhaustive sweeper: walks every input vector, lets it settle, and records
// the OR-AND function result into a truth-table register.
module pos_sweep_engine
  import pos_sweep_pkg::*;
#(
  parameter int unsigned N_IN    = 3,
  parameter int unsigned NCLAUSE = 2,
  parameter int unsigned SETTLE  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [NCLAUSE*N_IN-1:0] cfg_mask,
  output logic                    busy,
  output logic                    done,
  output logic [N_IN-1:0]         vec_out,
  output logic [(1<<N_IN)-1:0]    tt_out,
  output logic                    tt_valid
);

  localparam int unsigned TT_W   = 1 << N_IN;
  localparam int unsigned MASK_W = NCLAUSE * N_IN;
  localparam logic [N_IN-1:0]     VEC_LAST = '1;
  localparam logic [SETTLE_W-1:0] CNT_LAST = SETTLE_W'((SETTLE == 0) ? 0 : SETTLE - 1);
  // With no settle time, each vector goes straight to capture.
  localparam sweep_state_t FIRST_ST = (SETTLE == 0) ? CAPTURE : pos_sweep_pkg::SETTLE;

  sweep_state_t        state_q, state_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [MASK_W-1:0]   mask_q, mask_d;
  logic [N_IN-1:0]     vec_d;
  logic [TT_W-1:0]     tt_d;
  logic                busy_d, done_d, tt_valid_d;
  logic                f_c;

  pos_eval #(
    .N_IN    (N_IN),
    .NCLAUSE (NCLAUSE)
  ) u_eval (
    .vec  (vec_out),
    .mask (mask_q),
    .f_c  (f_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mask_d     = mask_q;
    vec_d      = vec_out;
    tt_d       = tt_out;
    busy_d     = busy;
    done_d     = 1'b0;
    tt_valid_d = tt_valid;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d    = FIRST_ST;
          mask_d     = cfg_mask;
          vec_d      = '0;
          cnt_d      = '0;
          tt_d       = '0;
          tt_valid_d = 1'b0;
          busy_d     = 1'b1;
        end
      end

      pos_sweep_pkg::SETTLE: begin
        if (abort) begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          tt_valid_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q + SETTLE_W'(1);
        end
      end

      CAPTURE: begin
        if (abort) begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          tt_valid_d = 1'b0;
        end else begin
          tt_d[vec_out] = f_c;
          // Terminal compare on all-ones so vec_out never wraps.
          if (vec_out == VEC_LAST) begin
            state_d    = DONE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            tt_valid_d = 1'b1;
          end else begin
            vec_d   = vec_out + N_IN'(1);
            cnt_d   = '0;
            state_d = FIRST_ST;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mask_q   <= '0;
      vec_out  <= '0;
      tt_out   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tt_valid <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      vec_out  <= vec_d;
      tt_out   <= tt_d;
      busy     <= busy_d;
      done     <= done_d;
      tt_valid <= tt_valid_d;
    end
  end

endmodule

// File: tb/tb_pos_sweep_engine.sv
// Bench for pos_sweep_engine: two instances (SETTLE=1 and SETTLE=0) checked
// against a truth-table model derived directly from the clause rules.
module tb_pos_sweep_engine;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       st [2];
  logic       ab [2];
  logic [5:0] mk [2];
  logic       bz [2];
  logic       dn [2];
  logic       tv [2];
  logic [2:0] vo [2];
  logic [7:0] tt [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pos_sweep_engine #(.N_IN(3), .NCLAUSE(2), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .abort(ab[0]), .cfg_mask(mk[0]),
    .busy(bz[0]), .done(dn[0]), .vec_out(vo[0]), .tt_out(tt[0]), .tt_valid(tv[0])
  );

  pos_sweep_engine #(.N_IN(3), .NCLAUSE(2), .SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .abort(ab[1]), .cfg_mask(mk[1]),
    .busy(bz[1]), .done(dn[1]), .vec_out(vo[1]), .tt_out(tt[1]), .tt_valid(tv[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Truth table from the clause rule: zero-mask clauses are ignored.
  function automatic logic [7:0] model_tt(input logic [5:0] m);
    logic [7:0] r;
    int cm;
    bit ok;
    r = '0;
    for (int v = 0; v < 8; v++) begin
      ok = 1'b1;
      for (int k = 0; k < 2; k++) begin
        cm = (int'(m) >> (3 * k)) & 7;
        if (cm != 0 && (v & cm) == 0) ok = 1'b0;
      end
      r[v] = ok;
    end
    return r;
  endfunction

  task automatic sweep(input int sel, input logic [5:0] m, input bit noise);
    logic [7:0] exp;
    int lat, n, bad;
    bit seen;
    exp = model_tt(m);
    lat = 8 * ((sel == 0 ? 1 : 0) + 1);
    st[sel] = 1'b1;
    mk[sel] = m;
    @(posedge clk); #1;
    st[sel] = 1'b0;
    if (noise) mk[sel] = 6'($urandom);
    chk("busy_after_start", 32'(bz[sel]), 32'd1);
    chk("vec_at_start", 32'(vo[sel]), 32'd0);
    chk("tt_valid_cleared", 32'(tv[sel]), 32'd0);
    n = 0; bad = 0; seen = 1'b0;
    while (!seen && n < lat + 20) begin
      n++;
      if (noise && (n == 3 || n == 10)) st[sel] = 1'b1;
      @(posedge clk); #1;
      st[sel] = 1'b0;
      if (dn[sel]) seen = 1'b1;
      else if (!bz[sel]) bad++;
    end
    chk("done_latency", 32'(n), 32'(lat));
    chk("busy_held", 32'(bad), 32'd0);
    chk("tt_out", 32'(tt[sel]), 32'(exp));
    chk("tt_valid_done", 32'(tv[sel]), 32'd1);
    chk("busy_done", 32'(bz[sel]), 32'd0);
    chk("vec_hold_last", 32'(vo[sel]), 32'd7);
    // In DONE, start and abort must both be ignored.
    if (noise) begin
      st[sel] = 1'b1;
      ab[sel] = 1'b1;
    end
    @(posedge clk); #1;
    st[sel] = 1'b0;
    ab[sel] = 1'b0;
    chk("done_one_cycle", 32'(dn[sel]), 32'd0);
    chk("busy_after_done", 32'(bz[sel]), 32'd0);
    chk("tt_valid_hold", 32'(tv[sel]), 32'd1);
    chk("tt_stable", 32'(tt[sel]), 32'(exp));
    chk("vec_stable", 32'(vo[sel]), 32'd7);
  endtask

  task automatic abort_test();
    int nd;
    st[0] = 1'b1;
    mk[0] = 6'b000_000;
    @(posedge clk); #1;
    st[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    ab[0] = 1'b1;
    @(posedge clk); #1;
    ab[0] = 1'b0;
    chk("abort_busy", 32'(bz[0]), 32'd0);
    chk("abort_tt_valid", 32'(tv[0]), 32'd0);
    chk("abort_done", 32'(dn[0]), 32'd0);
    chk("abort_partial_tt", 32'(tt[0]), 32'h03);
    nd = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (dn[0] || bz[0]) nd++;
    end
    chk("abort_stays_idle", 32'(nd), 32'd0);
  endtask

  task automatic reset_test();
    logic [5:0] m;
    m = 6'b001_110;
    st[0] = 1'b1;
    mk[0] = m;
    @(posedge clk); #1;
    st[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("pre_reset_partial", 32'(tt[0]), 32'(model_tt(m) & 8'h0F));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(bz[0]), 32'd0);
    chk("async_rst_tt", 32'(tt[0]), 32'd0);
    chk("async_rst_vec", 32'(vo[0]), 32'd0);
    chk("async_rst_valid", 32'(tv[0]), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] hold;
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b0;
      ab[i] = 1'b0;
      mk[i] = '0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", 32'(bz[i]), 32'd0);
      chk("rst_done", 32'(dn[i]), 32'd0);
      chk("rst_tt_valid", 32'(tv[i]), 32'd0);
      chk("rst_vec", 32'(vo[i]), 32'd0);
      chk("rst_tt", 32'(tt[i]), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    sweep(0, 6'b001_110, 1'b0);
    chk("tt_A8", 32'(tt[0]), 32'hA8);
    sweep(0, 6'b000_000, 1'b0);
    chk("tt_FF", 32'(tt[0]), 32'hFF);
    sweep(0, 6'b000_111, 1'b0);
    chk("tt_FE", 32'(tt[0]), 32'hFE);
    sweep(0, 6'b001_110, 1'b1);

    abort_test();
    sweep(0, 6'b001_110, 1'b0);
    chk("restart_A8", 32'(tt[0]), 32'hA8);

    reset_test();
    sweep(0, 6'b001_110, 1'b0);
    chk("post_reset_A8", 32'(tt[0]), 32'hA8);

    // start and abort together in IDLE: abort wins.
    hold = tt[0];
    st[0] = 1'b1;
    ab[0] = 1'b1;
    mk[0] = 6'b000_111;
    @(posedge clk); #1;
    st[0] = 1'b0;
    ab[0] = 1'b0;
    @(posedge clk); #1;
    chk("start_abort_busy", 32'(bz[0]), 32'd0);
    chk("start_abort_valid", 32'(tv[0]), 32'd1);
    chk("start_abort_tt", 32'(tt[0]), 32'(hold));

    sweep(1, 6'b001_110, 1'b0);
    chk("s0_tt_A8", 32'(tt[1]), 32'hA8);
    sweep(1, 6'b001_110, 1'b1);

    repeat (10) sweep(0, 6'($urandom), 1'($urandom_range(0, 1)));
    repeat (6)  sweep(1, 6'($urandom), 1'($urandom_range(0, 1)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
